// File: rtl/ysyx_24110015_key_lut_pipe.sv
// rtl/ysyx_24110015_key_lut_pipe.sv - programmable key->data lookup table with registered valid/ready response
// Optional multi-match flag output rsp_multi is built when YSYX_24110015_LUT_MULTIHIT_EN is defined.
module ysyx_24110015_key_lut_pipe #(
    parameter int  NR_ENTRY = 4,
    parameter int  KEY_LEN  = 8,
    parameter int  DATA_LEN = 32,
    localparam int IDX_W    = $clog2(NR_ENTRY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic [DATA_LEN-1:0] default_data,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [KEY_LEN-1:0]  req_key,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_LEN-1:0] rsp_data,
    output logic                rsp_hit,
    output logic [IDX_W-1:0]    rsp_idx
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
    ,
    output logic                rsp_multi
`endif
);

    logic [NR_ENTRY-1:0] vld_q, vld_d;
    logic [KEY_LEN-1:0]  key_q  [NR_ENTRY];
    logic [KEY_LEN-1:0]  key_d  [NR_ENTRY];
    logic [DATA_LEN-1:0] data_q [NR_ENTRY];
    logic [DATA_LEN-1:0] data_d [NR_ENTRY];

    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_LEN-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_hit_q, rsp_hit_d;
    logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;

    logic                hit_any;
    logic [IDX_W-1:0]    hit_idx;
    logic [DATA_LEN-1:0] hit_data;
    logic                xfer;

`ifdef YSYX_24110015_LUT_MULTIHIT_EN
    logic                rsp_multi_q, rsp_multi_d;
    logic                hit_multi;
`endif

    // Fixed-priority search: the first matching entry claims the result, later ones only flag multi.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        hit_data = default_data;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
        hit_multi = 1'b0;
`endif
        for (int i = 0; i < NR_ENTRY; i++) begin
            if (vld_q[i] && (key_q[i] == req_key)) begin
                if (!hit_any) begin
                    hit_any  = 1'b1;
                    hit_idx  = IDX_W'(i);
                    hit_data = data_q[i];
                end
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
                else begin
                    hit_multi = 1'b1;
                end
`endif
            end
        end
    end

    assign req_ready = !rsp_valid_q || rsp_ready;
    assign xfer      = req_valid && req_ready;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
        rsp_multi_d = rsp_multi_q;
`endif
        if (xfer) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = hit_data;
            rsp_hit_d   = hit_any;
            rsp_idx_d   = hit_idx;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
            rsp_multi_d = hit_multi;
`endif
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Index compare per entry means out-of-range wr_idx values select nothing.
    always_comb begin
        vld_d  = vld_q;
        key_d  = key_q;
        data_d = data_q;
        if (clr) begin
            vld_d = '0;
        end else if (wr_en) begin
            for (int i = 0; i < NR_ENTRY; i++) begin
                if (wr_idx == IDX_W'(i)) begin
                    vld_d[i]  = 1'b1;
                    key_d[i]  = wr_key;
                    data_d[i] = wr_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_idx_q   <= '0;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
            rsp_multi_q <= 1'b0;
`endif
            for (int i = 0; i < NR_ENTRY; i++) begin
                key_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            vld_q       <= vld_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
            rsp_multi_q <= rsp_multi_d;
`endif
            for (int i = 0; i < NR_ENTRY; i++) begin
                key_q[i]  <= key_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_idx   = rsp_idx_q;
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
    assign rsp_multi = rsp_multi_q;
`endif

endmodule

// File: tb/tb_ysyx_24110015_key_lut_pipe.sv
// tb/tb_ysyx_24110015_key_lut_pipe.sv - self-checking bench for the key lookup table pipe
module tb_ysyx_24110015_key_lut_pipe;

    logic        clk = 1'b0;
    logic        rst, clr, wr_en, req_valid, rsp_ready;
    logic [1:0]  wr_idx;
    logic [7:0]  wr_key, req_key;
    logic [31:0] wr_data, default_data;
    logic        req_ready, rsp_valid, rsp_hit;
    logic [31:0] rsp_data;
    logic [1:0]  rsp_idx;
    logic        rsp_multi_w;

    always #5 clk = ~clk;

    ysyx_24110015_key_lut_pipe dut (
        .clk(clk), .rst(rst), .clr(clr), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_key(wr_key), .wr_data(wr_data), .default_data(default_data),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_hit(rsp_hit), .rsp_idx(rsp_idx)
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
        , .rsp_multi(rsp_multi_w)
`endif
    );
`ifndef YSYX_24110015_LUT_MULTIHIT_EN
    assign rsp_multi_w = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference table and the response the consumer should currently see.
    bit          m_vld  [4];
    logic [7:0]  m_key  [4];
    logic [31:0] m_data [4];
    bit          exp_valid, exp_hit, exp_multi, exp_ready, got_ready;
    logic [1:0]  exp_idx;
    logic [31:0] exp_data;

    function automatic logic [35:0] dut_rsp();
        return {rsp_hit, rsp_idx, rsp_data, rsp_multi_w};
    endfunction

    function automatic logic [35:0] exp_rsp();
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
        return {exp_hit, exp_idx, exp_data, exp_multi};
`else
        return {exp_hit, exp_idx, exp_data, 1'b0};
`endif
    endfunction

    task automatic model_lookup(input logic [7:0] k, input logic [31:0] dflt,
                                output bit h, output logic [1:0] ix,
                                output logic [31:0] d, output bit m);
        int cnt = 0;
        int first = -1;
        for (int i = 0; i < 4; i++)
            if (m_vld[i] && m_key[i] == k) begin
                cnt++;
                if (first < 0) first = i;
            end
        h  = (cnt > 0);
        ix = h ? 2'(first) : 2'd0;
        d  = h ? m_data[first] : dflt;
        m  = (cnt >= 2);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_vld[i] = 0; m_key[i] = '0; m_data[i] = '0;
        end
        exp_valid = 0; exp_hit = 0; exp_idx = '0; exp_data = '0; exp_multi = 0;
    endtask

    task automatic idle();
        clr = 0; wr_en = 0; wr_idx = '0; wr_key = '0; wr_data = '0;
        req_valid = 0; req_key = '0; rsp_ready = 1; default_data = '0;
    endtask

    // Inputs are set at posedge+1; this advances the model and the clock, ending at posedge+1.
    task automatic step();
        bit h, m;
        logic [1:0] ix;
        logic [31:0] d;
        #1;
        got_ready = req_ready;
        exp_ready = !exp_valid || rsp_ready;
        if (req_valid && exp_ready) begin
            model_lookup(req_key, default_data, h, ix, d, m);
            exp_valid = 1; exp_hit = h; exp_idx = ix; exp_data = d; exp_multi = m;
        end else if (rsp_ready) begin
            exp_valid = 0;
        end
        if (clr) begin
            for (int i = 0; i < 4; i++) m_vld[i] = 0;
        end else if (wr_en) begin
            m_vld[wr_idx] = 1; m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input logic [1:0] ix, input logic [7:0] k, input logic [31:0] d);
        idle();
        wr_en = 1; wr_idx = ix; wr_key = k; wr_data = d;
        step();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({rsp_valid, rsp_hit, rsp_idx, rsp_data, rsp_multi_w} !== 37'd0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state got v=%b h=%b i=%0d d=%h m=%b rdy=%b want all 0, rdy=1",
                     rsp_valid, rsp_hit, rsp_idx, rsp_data, rsp_multi_w, req_ready);
        end
        rst = 0;
    endtask

    task automatic test_miss();
        req_valid = 1; req_key = 8'h12; default_data = 32'hDEAD;
        step();
        idle();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== 32'hDEAD || rsp_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL miss_default got v=%b h=%b i=%0d d=%h want v=1 h=0 i=0 d=0000dead",
                     rsp_valid, rsp_hit, rsp_idx, rsp_data);
        end
        step();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_drain got v=%b want v=0", rsp_valid);
        end
    endtask

    task automatic test_hit();
        write_entry(2'd2, 8'h12, 32'hA5A5_0001);
        req_valid = 1; req_key = 8'h12; default_data = 32'h1111_2222;
        step();
        idle();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b1 || rsp_idx !== 2'd2 || rsp_data !== 32'hA5A5_0001) begin
            n_fail++;
            $display("FAIL hit_idx2 got v=%b h=%b i=%0d d=%h want v=1 h=1 i=2 d=a5a50001",
                     rsp_valid, rsp_hit, rsp_idx, rsp_data);
        end
        step();
    endtask

    task automatic test_priority();
        write_entry(2'd1, 8'h40, 32'd1);
        write_entry(2'd3, 8'h40, 32'd3);
        req_valid = 1; req_key = 8'h40;
        step();
        idle();
        n_checks++;
        if (rsp_hit !== 1'b1 || rsp_idx !== 2'd1 || rsp_data !== 32'd1) begin
            n_fail++;
            $display("FAIL priority got h=%b i=%0d d=%h want h=1 i=1 d=00000001", rsp_hit, rsp_idx, rsp_data);
        end
`ifdef YSYX_24110015_LUT_MULTIHIT_EN
        n_checks++;
        if (rsp_multi_w !== 1'b1) begin
            n_fail++;
            $display("FAIL multi_flag got %b want 1", rsp_multi_w);
        end
`endif
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] keys [4];
        logic [35:0] held;
        keys[0] = 8'h12; keys[1] = 8'h40; keys[2] = 8'h99; keys[3] = 8'h12;
        req_valid = 1; req_key = keys[0]; default_data = 32'hBEEF;
        step();
        held = dut_rsp();
        rsp_ready = 0; req_key = keys[1];
        for (int c = 0; c < 3; c++) begin
            wr_en = (c == 1); wr_idx = 2'd2; wr_key = 8'h12; wr_data = 32'h7777;
            step();
            n_checks++;
            if (got_ready !== 1'b0 || rsp_valid !== 1'b1 || dut_rsp() !== held) begin
                n_fail++;
                $display("FAIL stall_hold c=%0d got rdy=%b v=%b rsp=%h want rdy=0 v=1 rsp=%h",
                         c, got_ready, rsp_valid, dut_rsp(), held);
            end
        end
        wr_en = 0;
        rsp_ready = 1;
        for (int c = 1; c < 4; c++) begin
            req_key = keys[c];
            step();
            n_checks++;
            if (got_ready !== 1'b1 || rsp_valid !== 1'b1 || dut_rsp() !== exp_rsp()) begin
                n_fail++;
                $display("FAIL b2b c=%0d got rdy=%b v=%b rsp=%h want rdy=1 v=1 rsp=%h",
                         c, got_ready, rsp_valid, dut_rsp(), exp_rsp());
            end
        end
        idle();
        step();
    endtask

    task automatic test_rw_same_cycle();
        wr_en = 1; wr_idx = 2'd0; wr_key = 8'h07; wr_data = 32'h0707_0707;
        req_valid = 1; req_key = 8'h07; default_data = 32'hD00D;
        step();
        wr_en = 0;
        n_checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 32'hD00D || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rw_same_cycle got v=%b h=%b d=%h want v=1 h=0 d=0000d00d", rsp_valid, rsp_hit, rsp_data);
        end
        step();
        idle();
        n_checks++;
        if (rsp_hit !== 1'b1 || rsp_idx !== 2'd0 || rsp_data !== 32'h0707_0707) begin
            n_fail++;
            $display("FAIL rw_next got h=%b i=%0d d=%h want h=1 i=0 d=07070707", rsp_hit, rsp_idx, rsp_data);
        end
        step();
    endtask

    task automatic test_clr_reset();
        clr = 1; wr_en = 1; wr_idx = 2'd1; wr_key = 8'h55; wr_data = 32'h5555;
        step();
        idle();
        req_valid = 1; req_key = 8'h55; default_data = 32'hC1C1;
        step();
        n_checks++;
        if (rsp_hit !== 1'b0 || rsp_data !== 32'hC1C1) begin
            n_fail++;
            $display("FAIL clr_priority got h=%b d=%h want h=0 d=0000c1c1", rsp_hit, rsp_data);
        end
        idle();
        write_entry(2'd3, 8'h66, 32'h6666);
        req_valid = 1; req_key = 8'h66; rsp_ready = 0;
        step();
        req_valid = 0;
        rst = 1;
        #1;
        n_checks++;
        if (rsp_valid !== 1'b0 || rsp_hit !== 1'b0 || rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b h=%b d=%h want v=0 h=0 d=0", rsp_valid, rsp_hit, rsp_data);
        end
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
        idle();
        req_valid = 1; req_key = 8'h66; default_data = 32'hAB;
        step();
        idle();
        n_checks++;
        if (rsp_valid !== 1'b1 || rsp_hit !== 1'b0 || rsp_data !== 32'hAB) begin
            n_fail++;
            $display("FAIL post_reset_empty got v=%b h=%b d=%h want v=1 h=0 d=000000ab", rsp_valid, rsp_hit, rsp_data);
        end
        step();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            clr          = ($urandom_range(0, 15) == 0);
            wr_en        = ($urandom_range(0, 2) == 0);
            wr_idx       = 2'($urandom_range(0, 3));
            wr_key       = 8'($urandom_range(0, 7));
            wr_data      = $urandom;
            req_valid    = ($urandom_range(0, 9) < 7);
            req_key      = 8'($urandom_range(0, 7));
            default_data = $urandom;
            rsp_ready    = ($urandom_range(0, 9) < 7);
            step();
            n_checks++;
            if (got_ready !== exp_ready || rsp_valid !== exp_valid ||
                (exp_valid && dut_rsp() !== exp_rsp())) begin
                n_fail++;
                $display("FAIL random c=%0d got rdy=%b v=%b rsp=%h want rdy=%b v=%b rsp=%h",
                         c, got_ready, rsp_valid, dut_rsp(), exp_ready, exp_valid, exp_rsp());
            end
        end
        idle();
        step();
    endtask

    initial begin
        test_reset();
        test_miss();
        test_hit();
        test_priority();
        test_back_to_back();
        test_rw_same_cycle();
        test_clr_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
